// File: rtl/y_row_server_pkg.sv
// Y-row server shared definitions: widths, FSM encoding, entry slicing.
// Imported by the interface, the row RAM and the server FSM.
package y_row_server_pkg;

  localparam int ELEM_W = 48;
  localparam int ELEMS  = 5;
  localparam int DATA_W = 256;
  localparam int PAD_LO = ELEMS * ELEM_W;

  localparam logic [2:0] S_IDLE     = 3'd0;
  localparam logic [2:0] S_RD_FETCH = 3'd1;
  localparam logic [2:0] S_RD_RESP  = 3'd2;
  localparam logic [2:0] S_WB_FETCH = 3'd3;
  localparam logic [2:0] S_WB_MERGE = 3'd4;

  typedef enum logic [2:0] {
    IDLE     = S_IDLE,
    RD_FETCH = S_RD_FETCH,
    RD_RESP  = S_RD_RESP,
    WB_FETCH = S_WB_FETCH,
    WB_MERGE = S_WB_MERGE
  } yState_t;

  // Bit offset of entry col; out-of-range columns map to 0
  // so the part-select never leaves the row.
  function automatic logic [7:0] elemOffset(
    input logic [2:0] col
  );
    logic [7:0] off;
    off = '0;
    if (col < 3'(ELEMS))
      off = 8'(col) * 8'(ELEM_W);
    return off;
  endfunction

endpackage

// File: rtl/y_row_server_if.sv
// Y-memory row request/response bundle.
// master = requester (filt_yVal), slave = y_row_server.
interface y_row_server_if #(
  parameter int ROW_W = 16
);
  import y_row_server_pkg::*;

  logic              rd_req;
  logic [ROW_W-1:0]  rd_row;
  logic [DATA_W-1:0] ymem_data;
  logic              yMemDataReady;
  logic              wr_req;
  logic [ROW_W-1:0]  wr_row;
  logic [2:0]        wr_col;
  logic [ELEM_W-1:0] wr_val;
  logic              wr_done;
  logic              busy;
  logic              err;

  modport master (
    output rd_req, rd_row,
    output wr_req, wr_row, wr_col, wr_val,
    input  ymem_data, yMemDataReady,
    input  wr_done, busy, err
  );

  modport slave (
    input  rd_req, rd_row,
    input  wr_req, wr_row, wr_col, wr_val,
    output ymem_data, yMemDataReady,
    output wr_done, busy, err
  );

endinterface

// File: rtl/y_row_server_ram.sv
// Single-port NUM_ROWS x DATA_W row store, registered read.
// Ports: clock, we/re strobes, addr, wData in, rData out.
module y_row_ram
  import y_row_server_pkg::*;
#(
  parameter int NUM_ROWS = 64,
  parameter int AW       = $clog2(NUM_ROWS)
) (
  input  logic              clock,
  input  logic              we,
  input  logic              re,
  input  logic [AW-1:0]     addr,
  input  logic [DATA_W-1:0] wData,
  output logic [DATA_W-1:0] rData
);

  logic [DATA_W-1:0] Register [NUM_ROWS];

  always_ff @(posedge clock) begin
    if (we)
      Register[addr] <= wData;
    if (re)
      rData <= Register[addr];
  end

endmodule

// File: rtl/y_row_server.sv
// Y-matrix row server: row reads and single-entry RMW writes.
// Ports: clock, reset (async, active-low), yBus (slave side).
module y_row_server
  import y_row_server_pkg::*;
#(
  parameter int NUM_ROWS = 64,
  parameter int ROW_W    = 16
) (
  input  logic           clock,
  input  logic           reset,
  y_row_server_if.slave  yBus
);

  localparam int AW = $clog2(NUM_ROWS);
  localparam logic [ROW_W-1:0] ROW_LIM =
    ROW_W'(NUM_ROWS);
  localparam logic [2:0] COL_MAX = 3'(ELEMS - 1);

  yState_t           state;
  logic [AW-1:0]     addrQ;
  logic [2:0]        colQ;
  logic [ELEM_W-1:0] valQ;
  logic              errQ;

  logic              ramWe;
  logic              ramRe;
  logic [DATA_W-1:0] ramQ;
  logic [DATA_W-1:0] mergeRow;

  // Out-of-range requests never touch the array.
  assign ramRe = !errQ &&
    (state == RD_FETCH || state == WB_FETCH);
  assign ramWe = !errQ && (state == WB_MERGE);

  // ramQ holds the fetched row during WB_MERGE.
  always_comb begin
    mergeRow = ramQ;
    mergeRow[elemOffset(colQ) +: ELEM_W] = valQ;
    mergeRow[DATA_W-1:PAD_LO] = '0;
  end

  y_row_ram #(
    .NUM_ROWS (NUM_ROWS),
    .AW       (AW)
  ) uRam (
    .clock (clock),
    .we    (ramWe),
    .re    (ramRe),
    .addr  (addrQ),
    .wData (mergeRow),
    .rData (ramQ)
  );

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state              <= IDLE;
      addrQ              <= '0;
      colQ               <= '0;
      valQ               <= '0;
      errQ               <= 1'b0;
      yBus.ymem_data     <= '0;
      yBus.yMemDataReady <= 1'b0;
      yBus.wr_done       <= 1'b0;
      yBus.busy          <= 1'b0;
      yBus.err           <= 1'b0;
    end else begin
      yBus.yMemDataReady <= 1'b0;
      yBus.wr_done       <= 1'b0;
      yBus.err           <= 1'b0;
      unique case (state)
        IDLE: begin
          // Write wins; a held read is served after it.
          if (yBus.wr_req) begin
            addrQ     <= yBus.wr_row[AW-1:0];
            colQ      <= yBus.wr_col;
            valQ      <= yBus.wr_val;
            errQ      <= (yBus.wr_row >= ROW_LIM) ||
                         (yBus.wr_col > COL_MAX);
            state     <= WB_FETCH;
            yBus.busy <= 1'b1;
          end else if (yBus.rd_req) begin
            addrQ     <= yBus.rd_row[AW-1:0];
            errQ      <= yBus.rd_row >= ROW_LIM;
            state     <= RD_FETCH;
            yBus.busy <= 1'b1;
          end
        end
        RD_FETCH: begin
          state <= RD_RESP;
        end
        RD_RESP: begin
          yBus.ymem_data     <= errQ ? '0 : ramQ;
          yBus.yMemDataReady <= 1'b1;
          yBus.err           <= errQ;
          yBus.busy          <= 1'b0;
          state              <= IDLE;
        end
        WB_FETCH: begin
          state <= WB_MERGE;
        end
        WB_MERGE: begin
          yBus.wr_done <= 1'b1;
          yBus.err     <= errQ;
          yBus.busy    <= 1'b0;
          state        <= IDLE;
        end
        default: begin
          yBus.busy <= 1'b0;
          state     <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_y_row_server.sv
// Scoreboarded bench for y_row_server.
// Preloads the row array, drives reads/writes, checks responses.
module tb_y_row_server;

  typedef struct {
    bit           isRd;
    bit           err;
    logic [255:0] data;
    int           cyc;
  } resp_t;

  logic clock = 1'b0;
  logic reset = 1'b0;
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;

  logic [255:0] model [64];
  resp_t expQ[$];
  resp_t gotQ[$];

  y_row_server_if #(.ROW_W(16)) yBus();

  y_row_server #(
    .NUM_ROWS (64),
    .ROW_W    (16)
  ) dut (
    .clock (clock),
    .reset (reset),
    .yBus  (yBus)
  );

  always #5 clock = ~clock;
  always @(posedge clock) cyc <= cyc + 1;

  always @(negedge clock) begin
    if (yBus.yMemDataReady || yBus.wr_done) begin
      resp_t r;
      r.isRd = yBus.yMemDataReady;
      r.err  = yBus.err;
      r.data = yBus.ymem_data;
      r.cyc  = cyc;
      gotQ.push_back(r);
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

  function automatic logic [255:0] rowPat(int i);
    logic [255:0] r;
    r = '0;
    for (int e = 0; e < 5; e++)
      r[e*48 +: 48] = {24'(i * 16 + e) ^ 24'hA50000,
                       24'(i * 7 + e + 1)};
    return r;
  endfunction

  function automatic void modelWrite(
    input logic [15:0] row, input logic [2:0] col,
    input logic [47:0] val);
    if (row < 64 && col < 5)
      model[row[5:0]][col*48 +: 48] = val;
  endfunction

  function automatic resp_t expRd(input logic [15:0] row);
    resp_t r;
    r.isRd = 1'b1;
    r.err  = row >= 64;
    r.data = (row < 64) ? model[row[5:0]] : '0;
    r.cyc  = 0;
    return r;
  endfunction

  function automatic resp_t expWr(
    input logic [15:0] row, input logic [2:0] col);
    resp_t r;
    r.isRd = 1'b0;
    r.err  = (row >= 64) || (col > 4);
    r.data = '0;
    r.cyc  = 0;
    return r;
  endfunction

  task automatic waitIdle();
    int k;
    k = 0;
    @(negedge clock);
    while (yBus.busy && k < 20) begin
      @(negedge clock);
      k++;
    end
    if (yBus.busy) begin
      checks++; errors++;
      $display("FAIL idle_timeout busy stuck");
    end
  endtask

  task automatic sendRead(input logic [15:0] row,
                          output int acc);
    waitIdle();
    yBus.rd_req = 1'b1;
    yBus.rd_row = row;
    expQ.push_back(expRd(row));
    @(posedge clock); #1;
    acc = cyc;
    yBus.rd_req = 1'b0;
  endtask

  task automatic sendWrite(input logic [15:0] row,
    input logic [2:0] col, input logic [47:0] val,
    output int acc);
    waitIdle();
    yBus.wr_req = 1'b1;
    yBus.wr_row = row;
    yBus.wr_col = col;
    yBus.wr_val = val;
    modelWrite(row, col, val);
    expQ.push_back(expWr(row, col));
    @(posedge clock); #1;
    acc = cyc;
    yBus.wr_req = 1'b0;
  endtask

  task automatic waitGot(int n);
    int k;
    k = 0;
    while (gotQ.size() < n && k < 60) begin
      @(posedge clock);
      k++;
    end
    if (gotQ.size() < n) begin
      checks++; errors++;
      $display("FAIL resp_timeout got %0d need %0d",
               gotQ.size(), n);
    end
  endtask

  task automatic test_reset();
    for (int i = 0; i < 64; i++) begin
      model[i] = rowPat(i);
      if (i == 3) model[i][47:0] = 48'hAABBCC112233;
      dut.uRam.Register[i] = model[i];
    end
    repeat (2) @(negedge clock);
    checks++;
    if (yBus.ymem_data !== '0) begin
      errors++;
      $display("FAIL rst_data got %h want 0", yBus.ymem_data);
    end
    checks++;
    if (yBus.yMemDataReady !== 1'b0) begin
      errors++;
      $display("FAIL rst_ready got %b want 0",
               yBus.yMemDataReady);
    end
    checks++;
    if (yBus.wr_done !== 1'b0) begin
      errors++;
      $display("FAIL rst_done got %b want 0", yBus.wr_done);
    end
    checks++;
    if (yBus.busy !== 1'b0 || yBus.err !== 1'b0) begin
      errors++;
      $display("FAIL rst_busy_err got %b%b want 00",
               yBus.busy, yBus.err);
    end
    reset = 1'b1;
  endtask

  task automatic test_read();
    int acc;
    logic [2:0] bz, rd;
    resp_t e, g;
    sendRead(16'd3, acc);
    for (int i = 0; i < 3; i++) begin
      @(negedge clock);
      bz[i] = yBus.busy;
      rd[i] = yBus.yMemDataReady;
    end
    checks++;
    if (bz !== 3'b011 || rd !== 3'b100) begin
      errors++;
      $display("FAIL rd_timing busy=%b ready=%b want 011 100",
               bz, rd);
    end
    @(posedge clock);
    waitGot(1);
    while (gotQ.size() > 0 && expQ.size() > 0) begin
      e = expQ.pop_front();
      g = gotQ.pop_front();
      checks++;
      if (g.isRd !== e.isRd || g.err !== e.err ||
          g.data !== e.data || g.cyc - acc != 2) begin
        errors++;
        $display("FAIL rd3 rd=%b err=%b lat=%0d data=%h want %b %b 2 %h",
                 g.isRd, g.err, g.cyc - acc, g.data,
                 e.isRd, e.err, e.data);
      end
    end
  endtask

  task automatic test_write();
    int acc, accW;
    resp_t e, g;
    sendWrite(16'd3, 3'd2, 48'h000100FFFF00, accW);
    sendRead(16'd3, acc);
    waitGot(2);
    for (int i = 0; i < 2; i++) begin
      if (gotQ.size() == 0 || expQ.size() == 0) break;
      e = expQ.pop_front();
      g = gotQ.pop_front();
      checks++;
      if (g.isRd !== e.isRd || g.err !== e.err ||
          (e.isRd && g.data !== e.data) ||
          (!e.isRd && g.cyc - accW != 2)) begin
        errors++;
        $display("FAIL wr3_%0d rd=%b err=%b data=%h want %b %b %h",
                 i, g.isRd, g.err, g.data,
                 e.isRd, e.err, e.data);
      end
      if (g.isRd) begin
        checks++;
        if (g.data[143:96] !== 48'h000100FFFF00 ||
            g.data[47:0] !== 48'hAABBCC112233 ||
            g.data[255:240] !== 16'h0) begin
          errors++;
          $display("FAIL wr3_fields e2=%h e0=%h pad=%h",
                   g.data[143:96], g.data[47:0],
                   g.data[255:240]);
        end
      end
    end
  endtask

  task automatic test_priority();
    int k;
    resp_t e, g;
    waitIdle();
    yBus.wr_req = 1'b1;
    yBus.wr_row = 16'd5;
    yBus.wr_col = 3'd4;
    yBus.wr_val = 48'h123456_654321;
    yBus.rd_req = 1'b1;
    yBus.rd_row = 16'd5;
    modelWrite(16'd5, 3'd4, 48'h123456_654321);
    expQ.push_back(expWr(16'd5, 3'd4));
    expQ.push_back(expRd(16'd5));
    @(posedge clock); #1;
    yBus.wr_req = 1'b0;
    k = 0;
    @(negedge clock);
    while (yBus.busy && k < 20) begin
      @(negedge clock);
      k++;
    end
    @(posedge clock); #1;
    yBus.rd_req = 1'b0;
    checks++;
    if (yBus.busy !== 1'b1) begin
      errors++;
      $display("FAIL prio_held_read busy=%b want 1", yBus.busy);
    end
    waitGot(2);
    for (int i = 0; i < 2; i++) begin
      if (gotQ.size() == 0 || expQ.size() == 0) break;
      e = expQ.pop_front();
      g = gotQ.pop_front();
      checks++;
      if (g.isRd !== e.isRd || g.err !== e.err ||
          (e.isRd && g.data !== e.data)) begin
        errors++;
        $display("FAIL prio_%0d rd=%b err=%b data=%h want %b %b %h",
                 i, g.isRd, g.err, g.data,
                 e.isRd, e.err, e.data);
      end
    end
  endtask

  task automatic test_range();
    int acc;
    resp_t e, g;
    sendRead(16'd64, acc);
    sendRead(16'h0103, acc);
    sendWrite(16'd7, 3'd5, 48'hDEADBEEF0001, acc);
    sendWrite(16'h8000, 3'd0, 48'hDEADBEEF0002, acc);
    sendRead(16'd7, acc);
    sendRead(16'd0, acc);
    waitGot(6);
    for (int i = 0; i < 6; i++) begin
      if (gotQ.size() == 0 || expQ.size() == 0) break;
      e = expQ.pop_front();
      g = gotQ.pop_front();
      checks++;
      if (g.isRd !== e.isRd || g.err !== e.err ||
          (e.isRd && g.data !== e.data)) begin
        errors++;
        $display("FAIL range_%0d rd=%b err=%b data=%h want %b %b %h",
                 i, g.isRd, g.err, g.data,
                 e.isRd, e.err, e.data);
      end
    end
  endtask

  task automatic test_reset_mid();
    int acc;
    resp_t e, g;
    sendWrite(16'd9, 3'd1, 48'hCAFE00_00BEEF, acc);
    void'(expQ.pop_back());
    model[9] = rowPat(9);
    reset = 1'b0;
    #1;
    checks++;
    if (yBus.ymem_data !== '0 || yBus.busy !== 1'b0 ||
        yBus.yMemDataReady !== 1'b0 ||
        yBus.wr_done !== 1'b0 || yBus.err !== 1'b0) begin
      errors++;
      $display("FAIL midrst_outs busy=%b rdy=%b done=%b err=%b data=%h",
               yBus.busy, yBus.yMemDataReady, yBus.wr_done,
               yBus.err, yBus.ymem_data);
    end
    repeat (3) @(negedge clock);
    reset = 1'b1;
    repeat (4) @(negedge clock);
    checks++;
    if (gotQ.size() != 0) begin
      errors++;
      $display("FAIL midrst_pulse got %0d want 0", gotQ.size());
      gotQ.delete();
    end
    sendRead(16'd9, acc);
    waitGot(1);
    while (gotQ.size() > 0 && expQ.size() > 0) begin
      e = expQ.pop_front();
      g = gotQ.pop_front();
      checks++;
      if (g.isRd !== e.isRd || g.err !== e.err ||
          g.data !== e.data) begin
        errors++;
        $display("FAIL midrst_row9 data=%h want %h",
                 g.data, e.data);
      end
    end
  endtask

  task automatic test_back_to_back();
    int k, prev;
    resp_t e, g;
    waitIdle();
    yBus.rd_req = 1'b1;
    yBus.rd_row = 16'd0;
    expQ.push_back(expRd(16'd0));
    for (int i = 0; i < 8; i++) begin
      k = 0;
      @(negedge clock);
      while (!yBus.yMemDataReady && k < 10) begin
        @(negedge clock);
        k++;
      end
      if (i < 7) begin
        yBus.rd_row = 16'(i + 1);
        expQ.push_back(expRd(16'(i + 1)));
      end else begin
        yBus.rd_req = 1'b0;
      end
    end
    @(posedge clock);
    waitGot(8);
    prev = -1;
    for (int i = 0; i < 8; i++) begin
      if (gotQ.size() == 0 || expQ.size() == 0) break;
      e = expQ.pop_front();
      g = gotQ.pop_front();
      checks++;
      if (g.isRd !== 1'b1 || g.err !== 1'b0 ||
          g.data !== e.data ||
          (prev >= 0 && g.cyc - prev != 3)) begin
        errors++;
        $display("FAIL b2b_%0d gap=%0d data=%h want 3 %h",
                 i, g.cyc - prev, g.data, e.data);
      end
      prev = g.cyc;
    end
  endtask

  initial begin
    yBus.rd_req = 1'b0;
    yBus.rd_row = '0;
    yBus.wr_req = 1'b0;
    yBus.wr_row = '0;
    yBus.wr_col = '0;
    yBus.wr_val = '0;
    test_reset();
    test_read();
    test_write();
    test_priority();
    test_range();
    test_reset_mid();
    test_back_to_back();
    repeat (4) @(negedge clock);
    checks++;
    if (gotQ.size() != 0 || expQ.size() != 0) begin
      errors++;
      $display("FAIL leftover got=%0d exp=%0d",
               gotQ.size(), expQ.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
